// File: rtl/adc_sample_sequencer_pkg.sv
// Shared types and frame layout for the serial ADC front end.
// Frames are 16 bits, MSB first; the 8-bit measurement sits in bits [11:4].
package mpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam int MEAS_W   = 8;
  localparam int FRAME_W  = 16;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 4;

  function automatic logic [FRAME_W-1:0] mosi_frame(input logic [2:0] addr);
    return {2'b00, addr, 11'b0};
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_sclk_gen.sv
// SCLK divider: idles high, toggles every CLK_DIV cycles while shifting.
// The divider also times SETUP/HOLD, so it runs whenever a transfer is active.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_shift,
  output logic o_sclk,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_sclk;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_run) begin
      r_div  <= '0;
      r_sclk <= 1'b1;
    end else begin
      r_div <= o_tick ? '0 : r_div + 1'b1;
      if (o_tick && i_shift) r_sclk <= ~r_sclk;
    end
  end

  assign o_tick = i_run && (r_div == DIV_MAX);
  assign o_fall = o_tick && i_shift && r_sclk;
  assign o_rise = o_tick && i_shift && !r_sclk;
  assign o_sclk = r_sclk;

endmodule

// File: rtl/adc_sample_sequencer.sv
// Reads iL/vg/vc from an 8-bit SPI ADC (CPOL=1) and publishes them as one
// double-buffered set with a single-cycle valid strobe.
//
// state | meaning
// IDLE  | waiting for start or auto tick
// SETUP | cs_n low, sclk high, CLK_DIV cycles
// SHIFT | four 16-bit frames, 64 SCLK periods
// HOLD  | sclk high, cs_n low, CLK_DIV cycles
// DONE  | shadow copied to outputs, sample_valid next cycle
module adc_sample_sequencer
  import mpc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned AUTO_PERIOD = 1000,
  parameter logic [2:0]  CH_IL       = 3'd0,
  parameter logic [2:0]  CH_VG       = 3'd1,
  parameter logic [2:0]  CH_VC       = 3'd2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              en,
  input  logic              start,
  input  logic              adc_miso,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic              adc_mosi,
  output logic [MEAS_W-1:0] iL,
  output logic [MEAS_W-1:0] vg,
  output logic [MEAS_W-1:0] vc,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TW-1:0] T_MAX = (AUTO_PERIOD > 0) ? TW'(AUTO_PERIOD - 1) : '0;
  localparam logic [3:0] CAP_IDX = 4'(FRAME_W - 1 - DATA_LSB);

  state_t r_state, w_next;
  logic [TW-1:0]           r_timer;
  logic [5:0]              r_bit;
  logic [DATA_MSB-DATA_LSB-1:0] r_rx;
  logic [MEAS_W-1:0]       r_sh_il, r_sh_vg, r_sh_vc;
  logic [MEAS_W-1:0]       r_il, r_vg, r_vc;
  logic                    r_cs_n, r_mosi, r_valid, r_overrun;
  logic                    w_auto, w_trig, w_run, w_shift;
  logic                    w_sclk, w_tick, w_rise, w_fall;
  logic [2:0]              w_addr;
  logic [FRAME_W-1:0]      w_frame;
  logic [MEAS_W-1:0]       w_byte;

  assign w_auto  = (AUTO_PERIOD != 0) && (r_timer == T_MAX);
  assign w_trig  = start || w_auto;
  assign w_shift = (r_state == SHIFT);
  assign w_run   = en && (r_state inside {SETUP, SHIFT, HOLD});
  assign w_addr  = (r_bit[5:4] == 2'd0) ? CH_IL : (r_bit[5:4] == 2'd1) ? CH_VG : CH_VC;
  assign w_frame = mosi_frame(w_addr);
  assign w_byte  = {r_rx, adc_miso};

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_run   (w_run),
    .i_shift (w_shift),
    .o_sclk  (w_sclk),
    .o_tick  (w_tick),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || !en || w_auto) r_timer <= '0;
    else                             r_timer <= r_timer + 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (en && w_trig) w_next = SETUP;
      SETUP: if (!en) w_next = IDLE; else if (w_tick) w_next = SHIFT;
      SHIFT: if (!en) w_next = IDLE; else if (w_rise && r_bit == 6'd63) w_next = HOLD;
      HOLD:  if (!en) w_next = IDLE; else if (w_tick) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state   <= IDLE;
      r_bit     <= '0;
      r_rx      <= '0;
      r_sh_il   <= '0;
      r_sh_vg   <= '0;
      r_sh_vc   <= '0;
      r_il      <= '0;
      r_vg      <= '0;
      r_vc      <= '0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cs_n    <= !(w_next inside {SETUP, SHIFT, HOLD});
      r_valid   <= (r_state == DONE) && en;
      r_overrun <= w_trig && (r_state != IDLE);
      if (r_state == DONE && en) begin
        r_il <= r_sh_il;
        r_vg <= r_sh_vg;
        r_vc <= r_sh_vc;
      end
      if (w_shift) begin
        if (w_fall) r_mosi <= w_frame[~r_bit[3:0]];
        if (w_rise) begin
          r_rx  <= w_byte[MEAS_W-2:0];
          r_bit <= r_bit + 6'd1;
          // Each frame returns the channel addressed one frame earlier.
          if (r_bit[3:0] == CAP_IDX) begin
            case (r_bit[5:4])
              2'd1: r_sh_il <= w_byte;
              2'd2: r_sh_vg <= w_byte;
              2'd3: r_sh_vc <= w_byte;
              default: ;
            endcase
          end
        end
      end else begin
        r_bit  <= '0;
        r_mosi <= 1'b0;
      end
    end
  end

  assign adc_sclk     = w_sclk;
  assign adc_cs_n     = r_cs_n;
  assign adc_mosi     = r_mosi;
  assign iL           = r_il;
  assign vg           = r_vg;
  assign vc           = r_vc;
  assign sample_valid = r_valid;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench: an ADC model feeds dut0 (external start only) while dut1
// free-runs on its auto timer.
module tb_adc_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dut0
  logic       rst0_n, en0, start0, miso0;
  logic       sclk0, cs0_n, mosi0, valid0, busy0, ovr0;
  logic [7:0] il0, vg0, vc0;

  adc_sample_sequencer #(.CLK_DIV(4), .AUTO_PERIOD(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst0_n), .en(en0), .start(start0), .adc_miso(miso0),
    .adc_sclk(sclk0), .adc_cs_n(cs0_n), .adc_mosi(mosi0), .iL(il0), .vg(vg0), .vc(vc0),
    .sample_valid(valid0), .busy(busy0), .overrun(ovr0)
  );

  // dut1
  logic       rst1_n, en1, start1, miso1;
  logic       sclk1, cs1_n, mosi1, valid1, busy1, ovr1;
  logic [7:0] il1, vg1, vc1;

  adc_sample_sequencer #(.CLK_DIV(4), .AUTO_PERIOD(600)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst1_n), .en(en1), .start(start1), .adc_miso(miso1),
    .adc_sclk(sclk1), .adc_cs_n(cs1_n), .adc_mosi(mosi1), .iL(il1), .vg(vg1), .vc(vc1),
    .sample_valid(valid1), .busy(busy1), .overrun(ovr1)
  );

  // ADC model for dut0: frame 0 returns 0x11, frame f returns the channel addressed in frame f-1
  logic [7:0]  ch_val [8];
  logic [2:0]  seen_addr [4];
  logic [15:0] m_cap = '0;
  int          m_bit = 0;

  always @(negedge cs0_n) m_bit = 0;

  always @(negedge sclk0) begin
    if (cs0_n === 1'b0 && m_bit < 64) begin
      logic [7:0]  d;
      logic [15:0] w;
      if (m_bit / 16 == 0) d = 8'h11;
      else                 d = ch_val[seen_addr[m_bit / 16 - 1]];
      w = {4'b1010, d, 4'b0101};
      miso0 = w[15 - (m_bit % 16)];
    end
  end

  always @(posedge sclk0) begin
    if (cs0_n === 1'b0) begin
      m_cap = {m_cap[14:0], mosi0};
      if (m_bit % 16 == 15 && m_bit < 64) seen_addr[m_bit / 16] = m_cap[13:11];
      m_bit++;
    end
  end

  typedef struct {
    int         t;
    logic [7:0] il, vg, vc;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc, e.t);
        chk("sample_set", {8'h0, il0, vg0, vc0}, {8'h0, e.il, e.vg, e.vc});
      end
    end
  end

  int ovr_cnt = 0;
  bit seen11 = 0;
  always @(negedge clk) begin
    if (ovr0 === 1'b1) ovr_cnt++;
    if (il0 === 8'h11 || vg0 === 8'h11 || vc0 === 8'h11) seen11 = 1;
  end

  // auto-trigger monitor for dut1
  int   sc_cnt = 0, last_sc = 0, last_v1 = -1, pulses1 = 0;
  logic prev_cs1 = 1'b1, prev_sclk1 = 1'b1;
  always @(negedge clk) begin
    if (rst1_n === 1'b1) begin
      if (prev_cs1 === 1'b1 && cs1_n === 1'b0) sc_cnt = 0;
      if (prev_sclk1 === 1'b0 && sclk1 === 1'b1 && cs1_n === 1'b0) sc_cnt++;
      if (prev_cs1 === 1'b0 && cs1_n === 1'b1) last_sc = sc_cnt;
      if (valid1 === 1'b1) begin
        if (last_v1 >= 0) chk("auto_period", cyc - last_v1, 600);
        chk("auto_sclk_count", last_sc, 64);
        last_v1 = cyc;
        pulses1++;
      end
    end
    prev_cs1   = cs1_n;
    prev_sclk1 = sclk1;
  end

  task automatic wait_until(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic launch(output int t, input bit push, input logic [7:0] a, b, c);
    for (int k = 0; k < 4; k++) seen_addr[k] = 3'd7;
    start0 = 1'b1;
    t = cyc + 1;
    if (push) q.push_back('{t + 521, a, b, c});
    @(negedge clk);
    start0 = 1'b0;
  endtask

  int T;

  initial begin
    rst0_n = 0; rst1_n = 0; en0 = 0; en1 = 0; start0 = 0; start1 = 0;
    miso0 = 0; miso1 = 0;
    for (int k = 0; k < 8; k++) ch_val[k] = 8'h00;
    for (int k = 0; k < 4; k++) seen_addr[k] = 3'd7;
    repeat (3) @(negedge clk);

    chk("rst_cs_n", cs0_n, 1);
    chk("rst_sclk", sclk0, 1);
    chk("rst_mosi", mosi0, 0);
    chk("rst_outputs", {il0, vg0, vc0}, 0);
    chk("rst_valid_busy_ovr", {valid0, busy0, ovr0}, 0);

    rst0_n = 1; rst1_n = 1; en0 = 1; en1 = 1;
    @(negedge clk);

    // basic transfer, frame-0 value must never surface
    ch_val[0] = 8'hA5; ch_val[1] = 8'h3C; ch_val[2] = 8'hFF;
    launch(T, 1, 8'hA5, 8'h3C, 8'hFF);
    wait_until(T + 300);
    chk("busy_mid", busy0, 1);
    chk("cs_n_mid", cs0_n, 0);
    wait_until(T + 530);
    chk("pending_t2", q.size(), 0);
    chk("mosi_addr0", seen_addr[0], 0);
    chk("mosi_addr1", seen_addr[1], 1);
    chk("mosi_addr2", seen_addr[2], 2);
    chk("mosi_addr3", seen_addr[3], 2);

    // start re-pulsed while busy
    ch_val[0] = 8'h5A; ch_val[1] = 8'hC3; ch_val[2] = 8'h01;
    ovr_cnt = 0;
    launch(T, 1, 8'h5A, 8'hC3, 8'h01);
    wait_until(T + 99);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("overrun_pulse", ovr0, 1);
    wait_until(T + 540);
    chk("overrun_count", ovr_cnt, 1);
    chk("pending_t4", q.size(), 0);

    // en dropped mid-transfer
    ch_val[0] = 8'h77; ch_val[1] = 8'h88; ch_val[2] = 8'h99;
    launch(T, 0, 8'h0, 8'h0, 8'h0);
    wait_until(T + 199);
    en0 = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", cs0_n, 1);
    chk("abort_sclk", sclk0, 1);
    chk("abort_busy", busy0, 0);
    wait_until(T + 560);
    chk("abort_keeps_outputs", {il0, vg0, vc0}, 24'h5AC301);
    en0 = 1'b1;
    @(negedge clk);
    launch(T, 1, 8'h77, 8'h88, 8'h99);
    wait_until(T + 530);
    chk("pending_t5", q.size(), 0);

    // reset mid-SHIFT
    launch(T, 0, 8'h0, 8'h0, 8'h0);
    wait_until(T + 199);
    rst0_n = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", cs0_n, 1);
    chk("midrst_sclk", sclk0, 1);
    chk("midrst_outputs", {il0, vg0, vc0}, 0);
    chk("midrst_busy", busy0, 0);
    repeat (4) @(negedge clk);
    rst0_n = 1'b1;
    wait_until(T + 800);
    chk("pending_t1", q.size(), 0);

    chk("frame0_never_seen", seen11, 0);
    chk("auto_pulses_ge3", pulses1 >= 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
